// File: rtl/ctl_game_if.sv
// Signal bundle between the game controller and the surrounding trigger,
// duck and display logic.
interface ctl_game_if;
  logic       new_frame;
  logic       start;
  logic       shot_fired;
  logic       hit;
  logic       miss;
  logic       duck_gone;
  logic       duck_spawn;
  logic       duck_kill;
  logic       duck_flee;
  logic       duck_active;
  logic       game_over;
  logic [3:0] ammo;
  logic [3:0] ducks_left;
  logic [3:0] score_ones;
  logic [3:0] score_tens;

  modport master (
    output new_frame, start, shot_fired, hit, miss, duck_gone,
    input  duck_spawn, duck_kill, duck_flee, duck_active, game_over,
    input  ammo, ducks_left, score_ones, score_tens
  );

  modport slave (
    input  new_frame, start, shot_fired, hit, miss, duck_gone,
    output duck_spawn, duck_kill, duck_flee, duck_active, game_over,
    output ammo, ducks_left, score_ones, score_tens
  );
endinterface

// File: rtl/ctl_game.sv
// Duck-hunt game sequencer: spawns ducks, tracks ammo, BCD score and ducks
// remaining, and issues one-cycle spawn/kill/flee commands to duck control.
module ctl_game #(
  parameter int AMMO_PER_DUCK  = 3,
  parameter int DUCKS_PER_GAME = 9,
  parameter int FLY_TIMEOUT    = 600,
  parameter int PAUSE_FRAMES   = 60
) (
  input  logic       clk,
  input  logic       rst,
  ctl_game_if.slave  g
);

  localparam int CNT_MAX = (FLY_TIMEOUT > PAUSE_FRAMES) ? FLY_TIMEOUT : PAUSE_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {IDLE, SPAWN, FLY, FALL, FLEE, PAUSE, OVER} state_t;

  state_t           state;
  logic             start_q;
  logic [CNT_W-1:0] frame_cnt;
  logic             start_rise;
  logic             fly_timeout;
  logic             pause_done;
  logic             spawn_now;
  logic [3:0]       ammo_next;

  function automatic logic [7:0] bcd_inc(input logic [7:0] s);
    if (s == 8'h99)
      return s;
    else if (s[3:0] == 4'd9)
      return {s[7:4] + 4'd1, 4'd0};
    else
      return {s[7:4], s[3:0] + 4'd1};
  endfunction

  always_comb begin
    start_rise  = g.start & ~start_q;
    fly_timeout = g.new_frame && (frame_cnt == CNT_W'(FLY_TIMEOUT - 1));
    pause_done  = g.new_frame && (frame_cnt == CNT_W'(PAUSE_FRAMES - 1));
    ammo_next   = (g.shot_fired && (g.ammo != 4'd0)) ? g.ammo - 4'd1 : g.ammo;
    spawn_now   = (((state == IDLE) || (state == OVER)) && start_rise) ||
                  ((state == PAUSE) && pause_done && (g.ducks_left != 4'd0));
  end

  // History resets high so a start level already present at reset release
  // is not mistaken for a rising edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      start_q       <= 1'b1;
      frame_cnt     <= '0;
      g.duck_spawn  <= 1'b0;
      g.duck_kill   <= 1'b0;
      g.duck_flee   <= 1'b0;
      g.duck_active <= 1'b0;
      g.game_over   <= 1'b0;
      g.ammo        <= 4'd0;
      g.ducks_left  <= 4'd0;
      g.score_ones  <= 4'd0;
      g.score_tens  <= 4'd0;
    end else begin
      start_q      <= g.start;
      g.duck_spawn <= 1'b0;
      g.duck_kill  <= 1'b0;
      g.duck_flee  <= 1'b0;
      if (spawn_now) begin
        state        <= SPAWN;
        g.duck_spawn <= 1'b1;
        g.ammo       <= 4'(AMMO_PER_DUCK);
        g.game_over  <= 1'b0;
        frame_cnt    <= '0;
        if (state == PAUSE) begin
          g.ducks_left <= g.ducks_left - 4'd1;
        end else begin
          g.ducks_left <= 4'(DUCKS_PER_GAME - 1);
          g.score_ones <= 4'd0;
          g.score_tens <= 4'd0;
        end
      end else begin
        case (state)
          SPAWN: begin
            state         <= FLY;
            g.duck_active <= 1'b1;
          end
          FLY: begin
            g.ammo <= ammo_next;
            if (g.new_frame) frame_cnt <= frame_cnt + 1'b1;
            // A hit wins over a simultaneous miss or timeout.
            if (g.hit) begin
              state                        <= FALL;
              g.duck_kill                  <= 1'b1;
              g.duck_active                <= 1'b0;
              {g.score_tens, g.score_ones} <= bcd_inc({g.score_tens, g.score_ones});
            end else if ((g.miss && (ammo_next == 4'd0)) || fly_timeout) begin
              state         <= FLEE;
              g.duck_flee   <= 1'b1;
              g.duck_active <= 1'b0;
            end
          end
          FALL, FLEE: begin
            if (g.duck_gone) begin
              state     <= PAUSE;
              frame_cnt <= '0;
            end
          end
          PAUSE: begin
            if (g.new_frame) frame_cnt <= frame_cnt + 1'b1;
            if (pause_done) begin
              state       <= OVER;
              g.game_over <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ctl_game.sv
// Directed bench for ctl_game: expected output snapshots are queued as each
// step is driven and compared one cycle later.
module tb_ctl_game;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  ctl_game_if bus();

  ctl_game dut (
    .clk (clk),
    .rst (rst),
    .g   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic       spawn;
    logic       kill;
    logic       flee;
    logic       active;
    logic       over;
    logic [3:0] ammo;
    logic [3:0] dl;
    logic [7:0] score;
  } exp_t;

  exp_t sb[$];

  task automatic expect_out(input string tag, input logic sp, input logic k,
                            input logic f, input logic a, input logic [3:0] am,
                            input logic [3:0] dl, input logic [7:0] sc,
                            input logic ov);
    exp_t e;
    e.tag = tag; e.spawn = sp; e.kill = k; e.flee = f; e.active = a;
    e.ammo = am; e.dl = dl; e.score = sc; e.over = ov;
    sb.push_back(e);
  endtask

  task automatic chk(input string tag, input string fld,
                     input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, exp);
    end
  endtask

  task automatic compare_pop();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard observed=empty expected=entry");
    end else begin
      e = sb.pop_front();
      chk(e.tag, "duck_spawn",  {3'b0, bus.duck_spawn},  {3'b0, e.spawn});
      chk(e.tag, "duck_kill",   {3'b0, bus.duck_kill},   {3'b0, e.kill});
      chk(e.tag, "duck_flee",   {3'b0, bus.duck_flee},   {3'b0, e.flee});
      chk(e.tag, "duck_active", {3'b0, bus.duck_active}, {3'b0, e.active});
      chk(e.tag, "game_over",   {3'b0, bus.game_over},   {3'b0, e.over});
      chk(e.tag, "ammo",        bus.ammo,                e.ammo);
      chk(e.tag, "ducks_left",  bus.ducks_left,          e.dl);
      chk(e.tag, "score_tens",  bus.score_tens,          e.score[7:4]);
      chk(e.tag, "score_ones",  bus.score_ones,          e.score[3:0]);
    end
  endtask

  // One clock with the given pulses; compares if an expectation is pending.
  task automatic step(input logic nf, input logic sf, input logic h,
                      input logic m, input logic gone);
    bus.new_frame = nf; bus.shot_fired = sf; bus.hit = h; bus.miss = m;
    bus.duck_gone = gone;
    @(posedge clk);
    #1;
    bus.new_frame = 0; bus.shot_fired = 0; bus.hit = 0; bus.miss = 0;
    bus.duck_gone = 0;
    if (sb.size() != 0) compare_pop();
  endtask

  task automatic fly_start(input logic [3:0] dl, input logic [7:0] sc);
    expect_out("fly", 0, 0, 0, 1, 4'd3, dl, sc, 0);
    step(0, 0, 0, 0, 0);
  endtask

  task automatic kill_duck(input string tag, input logic [3:0] dl, input logic [7:0] sc);
    expect_out(tag, 0, 1, 0, 0, 4'd3, dl, sc, 0);
    step(0, 0, 1, 0, 0);
    expect_out({tag, "_gone"}, 0, 0, 0, 0, 4'd3, dl, sc, 0);
    step(0, 0, 0, 0, 1);
  endtask

  // From PAUSE entry: 59 frames stay quiet, the 60th spawns or ends the game.
  task automatic pause_check(input string tag, input logic [3:0] am,
                             input logic [3:0] dl, input logic [7:0] sc,
                             input logic last);
    repeat (59) step(1, 0, 0, 0, 0);
    expect_out({tag, "_wait"}, 0, 0, 0, 0, am, dl, sc, 0);
    step(0, 0, 0, 0, 0);
    if (last) expect_out({tag, "_over"}, 0, 0, 0, 0, am, 4'd0, sc, 1);
    else      expect_out({tag, "_spawn"}, 1, 0, 0, 0, 4'd3, dl - 4'd1, sc, 0);
    step(1, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b0;
    bus.start = 0; bus.new_frame = 0; bus.shot_fired = 0;
    bus.hit = 0; bus.miss = 0; bus.duck_gone = 0;
    #3;
    expect_out("reset", 0, 0, 0, 0, 4'd0, 4'd0, 8'h00, 0);
    compare_pop();
    @(posedge clk); #1;
    rst = 1'b1;
    expect_out("idle", 0, 0, 0, 0, 4'd0, 4'd0, 8'h00, 0);
    step(0, 0, 0, 0, 0);

    // Duck 1: start, then run out of ammo on misses
    bus.start = 1;
    expect_out("spawn1", 1, 0, 0, 0, 4'd3, 4'd8, 8'h00, 0);
    step(0, 0, 0, 0, 0);
    fly_start(4'd8, 8'h00);
    expect_out("miss1", 0, 0, 0, 1, 4'd2, 4'd8, 8'h00, 0);
    step(0, 1, 0, 1, 0);
    expect_out("miss2", 0, 0, 0, 1, 4'd1, 4'd8, 8'h00, 0);
    step(0, 1, 0, 1, 0);
    expect_out("miss3", 0, 0, 1, 0, 4'd0, 4'd8, 8'h00, 0);
    step(0, 1, 0, 1, 0);
    expect_out("shot4", 0, 0, 0, 0, 4'd0, 4'd8, 8'h00, 0);
    step(0, 1, 1, 1, 0);
    expect_out("gone1", 0, 0, 0, 0, 4'd0, 4'd8, 8'h00, 0);
    step(0, 0, 0, 0, 1);
    pause_check("p1", 4'd0, 4'd8, 8'h00, 0);
    fly_start(4'd7, 8'h00);

    // Duck 2: hit together with the last shot and a miss
    expect_out("d2shot1", 0, 0, 0, 1, 4'd2, 4'd7, 8'h00, 0);
    step(0, 1, 0, 1, 0);
    expect_out("d2shot2", 0, 0, 0, 1, 4'd1, 4'd7, 8'h00, 0);
    step(0, 1, 0, 1, 0);
    expect_out("d2hit", 0, 1, 0, 0, 4'd0, 4'd7, 8'h01, 0);
    step(0, 1, 1, 1, 0);
    expect_out("gone2", 0, 0, 0, 0, 4'd0, 4'd7, 8'h01, 0);
    step(0, 0, 0, 0, 1);
    pause_check("p2", 4'd0, 4'd7, 8'h01, 0);
    fly_start(4'd6, 8'h01);

    // Duck 3: flies off after 600 frames untouched
    repeat (599) step(1, 0, 0, 0, 0);
    expect_out("d3wait", 0, 0, 0, 1, 4'd3, 4'd6, 8'h01, 0);
    step(0, 0, 0, 0, 0);
    expect_out("d3timeout", 0, 0, 1, 0, 4'd3, 4'd6, 8'h01, 0);
    step(1, 0, 0, 0, 0);
    expect_out("gone3", 0, 0, 0, 0, 4'd3, 4'd6, 8'h01, 0);
    step(0, 0, 0, 0, 1);
    pause_check("p3", 4'd3, 4'd6, 8'h01, 0);
    fly_start(4'd5, 8'h01);

    // Duck 4: score preset to 09 carries to 10
    force bus.score_ones = 4'd9;
    force bus.score_tens = 4'd0;
    #1;
    release bus.score_ones;
    release bus.score_tens;
    kill_duck("k4", 4'd5, 8'h10);
    pause_check("p4", 4'd3, 4'd5, 8'h10, 0);
    fly_start(4'd4, 8'h10);

    // Duck 5: score preset to 99 saturates
    force bus.score_ones = 4'd9;
    force bus.score_tens = 4'd9;
    #1;
    release bus.score_ones;
    release bus.score_tens;
    kill_duck("k5", 4'd4, 8'h99);
    pause_check("p5", 4'd3, 4'd4, 8'h99, 0);
    fly_start(4'd3, 8'h99);

    for (int d = 3; d >= 1; d--) begin
      kill_duck("k", 4'(d), 8'h99);
      pause_check("p", 4'd3, 4'(d), 8'h99, 0);
      fly_start(4'(d - 1), 8'h99);
    end
    kill_duck("k9", 4'd0, 8'h99);
    pause_check("p9", 4'd3, 4'd0, 8'h99, 1);
    expect_out("over_hold", 0, 0, 0, 0, 4'd3, 4'd0, 8'h99, 1);
    step(0, 1, 1, 1, 0);

    // Restart from OVER on a fresh start edge
    bus.start = 0;
    expect_out("over_low", 0, 0, 0, 0, 4'd3, 4'd0, 8'h99, 1);
    step(0, 0, 0, 0, 0);
    bus.start = 1;
    expect_out("restart", 1, 0, 0, 0, 4'd3, 4'd8, 8'h00, 0);
    step(0, 0, 0, 0, 0);
    fly_start(4'd8, 8'h00);
    expect_out("r_shot", 0, 0, 0, 1, 4'd2, 4'd8, 8'h00, 0);
    step(0, 1, 0, 0, 0);

    // Asynchronous reset mid-flight with start held high
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    expect_out("midreset", 0, 0, 0, 0, 4'd0, 4'd0, 8'h00, 0);
    compare_pop();
    @(posedge clk); #1;
    rst = 1'b1;
    expect_out("rel1", 0, 0, 0, 0, 4'd0, 4'd0, 8'h00, 0);
    step(0, 0, 0, 0, 0);
    expect_out("rel2", 0, 0, 0, 0, 4'd0, 4'd0, 8'h00, 0);
    step(0, 0, 0, 0, 0);
    bus.start = 0;
    expect_out("rel_low", 0, 0, 0, 0, 4'd0, 4'd0, 8'h00, 0);
    step(0, 0, 0, 0, 0);
    bus.start = 1;
    expect_out("rel_spawn", 1, 0, 0, 0, 4'd3, 4'd8, 8'h00, 0);
    step(0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ctl_game.md
CTL_GAME -- requirements
Module: ctl_game

Interface
REQ-001 The block SHALL have parameter AMMO_PER_DUCK, default 3, meaning shots granted per duck (1..9).
REQ-002 The block SHALL have parameter DUCKS_PER_GAME, default 9, meaning ducks per game (1..9).
REQ-003 The block SHALL have parameter FLY_TIMEOUT, default 600, meaning frames before an unhit duck flees.
REQ-004 The block SHALL have parameter PAUSE_FRAMES, default 60, meaning frames between ducks.
REQ-005 The block SHALL have the port clk, input, 1 bit: the single clock for all state.
REQ-006 The block SHALL have the port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The block SHALL have the port new_frame, input, 1 bit: one-cycle pulse per video frame.
REQ-008 The block SHALL have the port start, input, 1 bit: level; a game starts on its rising edge.
REQ-009 The block SHALL have the ports shot_fired, hit and miss, inputs, 1 bit each: one-cycle pulses from trigger logic.
REQ-010 The block SHALL have the port duck_gone, input, 1 bit: pulse when the duck has left the screen (fallen or flown off).
REQ-011 The block SHALL have the ports duck_spawn, duck_kill and duck_flee, outputs, 1 bit each: one-cycle commands to duck control.
REQ-012 The block SHALL have the port duck_active, output, 1 bit: high while in FLY.
REQ-013 The block SHALL have the port ammo, output, 4 bits: remaining shots as a BCD digit.
REQ-014 The block SHALL have the port ducks_left, output, 4 bits: ducks still to spawn, BCD.
REQ-015 The block SHALL have the ports score_ones and score_tens, outputs, 4 bits each: score in BCD.
REQ-016 The block SHALL have the port game_over, output, 1 bit: high in state OVER.
REQ-017 All outputs SHALL be registered.

Function
REQ-018 States SHALL be IDLE, SPAWN, FLY, FALL, FLEE, PAUSE and OVER.
REQ-019 IDLE -> SPAWN on the start rising edge; score is cleared, ducks_left=DUCKS_PER_GAME.
REQ-020 SPAWN SHALL last exactly 1 cycle: duck_spawn=1, ammo=AMMO_PER_DUCK, ducks_left decremented, frame counter cleared, then -> FLY.
REQ-021 FLY: each shot_fired with ammo>0 SHALL decrement ammo by 1; shot_fired with ammo=0 SHALL be ignored.
REQ-022 FLY: hit SHALL assert duck_kill for 1 cycle, increment score in BCD (09->10, 99 saturates), and go -> FALL.
REQ-023 FLY: hit has priority over miss and over timeout in the same cycle; hit and shot_fired together SHALL both take effect.
REQ-024 FLY: miss with ammo=0 after the update, or frame counter reaching FLY_TIMEOUT, SHALL assert duck_flee for 1 cycle and go -> FLEE.
REQ-025 The frame counter SHALL increment only on new_frame and only in FLY and PAUSE.
REQ-026 FALL and FLEE SHALL wait for duck_gone, then -> PAUSE with the frame counter cleared; hit, miss and shot_fired SHALL be ignored there.
REQ-027 PAUSE -> SPAWN after PAUSE_FRAMES new_frame pulses if ducks_left>0, else -> OVER.
REQ-028 OVER SHALL hold score; a start rising edge SHALL go -> IDLE-equivalent restart (directly to SPAWN with score cleared).
REQ-029 Command pulses SHALL never be asserted in the same cycle as each other.
REQ-030 The start edge detector SHALL be registered; start held high from reset SHALL NOT start a game.

Reset
REQ-031 On rst=0, regardless of clock: state=IDLE, ammo=0, ducks_left=0, score=00, command pulses=0, duck_active=0, game_over=0, counters=0, and the start history register=1.
REQ-032 Reset mid-game SHALL abandon the game; no command pulse SHALL appear in the first cycle after release.

Verification
REQ-033 The bench SHALL check: start pulse -> 1 cycle later duck_spawn=1, ammo=3, ducks_left=8; next cycle duck_active=1.
REQ-034 The bench SHALL check: in FLY, 3 shot_fired+miss pairs -> ammo 2,1,0, duck_flee on the third miss, state FLEE; a 4th shot is ignored.
REQ-035 The bench SHALL check: hit+shot_fired together with ammo=1 -> duck_kill, ammo=0, score 00->01, no duck_flee.
REQ-036 The bench SHALL check: score=09 and hit -> score_tens=1, score_ones=0; score=99 and hit -> stays 99.
REQ-037 The bench SHALL check: no shots for 600 new_frames -> duck_flee; after duck_gone plus 60 frames -> duck_spawn; after the 9th duck -> game_over=1.
REQ-038 The bench SHALL check: rst low asserted mid-FLY -> all outputs immediately at reset values; start held high through release causes no spawn.
